// File: rtl/btle_rx_pkg.sv
// Shared definitions for the BTLE receive deframer: FSM encoding, abort codes,
// CRC polynomial and advertising channel numbers.
package btle_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } rx_state_e;

  localparam logic [1:0] ABORT_NONE    = 2'd0;
  localparam logic [1:0] ABORT_LENGTH  = 2'd1;
  localparam logic [1:0] ABORT_GAP     = 2'd2;
  localparam logic [1:0] ABORT_RESTART = 2'd3;

  // x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1
  localparam logic [23:0] CRC_POLY = 24'h00065B;

  localparam logic [5:0] ADV_CH_37 = 6'd37;
  localparam logic [5:0] ADV_CH_38 = 6'd38;
  localparam logic [5:0] ADV_CH_39 = 6'd39;

  function automatic logic is_adv_channel(input logic [5:0] ch);
    return (ch == ADV_CH_37) || (ch == ADV_CH_38) || (ch == ADV_CH_39);
  endfunction

endpackage

// File: rtl/btle_crc24_lfsr.sv
// Serial CRC LFSR with synchronous seed load and per-bit enable. Exposes the
// value the register will take if the current bit is clocked in.
module btle_crc24_lfsr
  import btle_rx_pkg::*;
#(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] crc_next
);

  logic [WIDTH-1:0] crc_q;
  logic             fb;

  // Division-style register: clocking the transmitted CRC bits after the
  // message drives the register to zero when the frame is intact.
  assign fb       = crc_q[WIDTH-1] ^ din;
  assign crc_next = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else if (load) begin
      crc_q <= init;
    end else if (en) begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/btle_rx_deframer.sv
// BTLE receive deframer: assembles descrambled bits into header/payload
// octets, decodes the length field, checks the CRC and supervises bit gaps.
module btle_rx_deframer
  import btle_rx_pkg::*;
#(
  parameter int LEN_WIDTH           = 8,
  parameter int MAX_PAYLOAD         = 255,
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int GAP_TIMEOUT         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           legacy_mode,
  input  logic [5:0]                     channel_number,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_init,
  input  logic                           info_bit,
  input  logic                           bit_valid,
  output logic [7:0]                     octet,
  output logic                           octet_valid,
  output logic                           octet_last,
  output logic [LEN_WIDTH-1:0]           payload_length,
  output logic                           payload_length_valid,
  output logic                           decode_end,
  output logic                           crc_ok,
  output logic                           abort,
  output logic [1:0]                     abort_code,
  output logic                           busy
);

  localparam int BCW   = $clog2(8 * (MAX_PAYLOAD + 5) + 1);
  localparam int TMR_W = $clog2(GAP_TIMEOUT + 1);

  rx_state_e state_q, state_d;
  logic [6:0]                     shreg_q, shreg_d;
  logic [BCW-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [LEN_WIDTH-1:0]           oct_cnt_q, oct_cnt_d;
  logic [TMR_W-1:0]               timer_q, timer_d;
  logic [7:0]                     octet_q, octet_d;
  logic                           octet_valid_q, octet_valid_d;
  logic                           octet_last_q, octet_last_d;
  logic [LEN_WIDTH-1:0]           payload_length_q, payload_length_d;
  logic                           plv_q, plv_d;
  logic                           decode_end_q, decode_end_d;
  logic                           crc_ok_q, crc_ok_d;
  logic                           abort_q, abort_d;
  logic [1:0]                     abort_code_q, abort_code_d;

  logic [7:0]                     octet_now;
  logic [7:0]                     len_raw;
  logic [LEN_WIDTH-1:0]           len_dec;
  logic [32:0]                    len_margin;
  logic                           too_long;
  logic                           restart;
  logic                           bit_acc;
  logic [CRC_STATE_BIT_WIDTH-1:0] crc_next;

  assign busy      = (state_q != ST_IDLE);
  assign restart   = start & busy & ~rst;
  assign bit_acc   = bit_valid & ~start & busy;
  assign octet_now = {info_bit, shreg_q};

  always_comb begin
    len_raw = octet_now;
    if (legacy_mode) begin
      len_raw = is_adv_channel(channel_number) ? {2'b00, octet_now[5:0]}
                                               : {3'b000, octet_now[4:0]};
    end
  end

  assign len_dec    = LEN_WIDTH'(len_raw);
  // Borrow out of MAX_PAYLOAD - length flags an oversize frame.
  assign len_margin = 33'(MAX_PAYLOAD) - 33'(len_dec);
  assign too_long   = len_margin[32];

  btle_crc24_lfsr #(
    .WIDTH (CRC_STATE_BIT_WIDTH)
  ) u_crc (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .init     (crc_init),
    .en       (bit_acc),
    .din      (info_bit),
    .crc_next (crc_next)
  );

  always_comb begin
    state_d          = state_q;
    shreg_d          = shreg_q;
    bit_cnt_d        = bit_cnt_q;
    oct_cnt_d        = oct_cnt_q;
    timer_d          = timer_q;
    octet_d          = octet_q;
    octet_valid_d    = 1'b0;
    octet_last_d     = 1'b0;
    payload_length_d = payload_length_q;
    plv_d            = 1'b0;
    decode_end_d     = 1'b0;
    crc_ok_d         = crc_ok_q;
    abort_d          = 1'b0;
    abort_code_d     = ABORT_NONE;

    if (start) begin
      state_d   = ST_HEADER;
      shreg_d   = '0;
      bit_cnt_d = '0;
      oct_cnt_d = '0;
      timer_d   = '0;
      crc_ok_d  = 1'b0;
    end else if (busy) begin
      if (bit_valid) begin
        timer_d = '0;
        shreg_d = octet_now[7:1];
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + BCW'(1);
        if (bit_cnt_q[2:0] == 3'd7) begin
          oct_cnt_d = oct_cnt_q + LEN_WIDTH'(1);
          case (state_q)
            ST_HEADER: begin
              octet_d       = octet_now;
              octet_valid_d = 1'b1;
              if (oct_cnt_q != '0) begin
                oct_cnt_d = '0;
                if (too_long) begin
                  abort_d      = 1'b1;
                  abort_code_d = ABORT_LENGTH;
                  state_d      = ST_IDLE;
                end else begin
                  payload_length_d = len_dec;
                  plv_d            = 1'b1;
                  if (len_dec == '0) begin
                    octet_last_d = 1'b1;
                    state_d      = ST_CRC;
                  end else begin
                    state_d = ST_PAYLOAD;
                  end
                end
              end
            end
            ST_PAYLOAD: begin
              octet_d       = octet_now;
              octet_valid_d = 1'b1;
              if (oct_cnt_q == payload_length_q - LEN_WIDTH'(1)) begin
                octet_last_d = 1'b1;
                oct_cnt_d    = '0;
                state_d      = ST_CRC;
              end
            end
            ST_CRC: begin
              if (oct_cnt_q == LEN_WIDTH'(2)) begin
                decode_end_d = 1'b1;
                crc_ok_d     = (crc_next == '0);
                state_d      = ST_IDLE;
              end
            end
            default: ;
          endcase
        end
      end else if (timer_q == TMR_W'(GAP_TIMEOUT - 1)) begin
        abort_d      = 1'b1;
        abort_code_d = ABORT_GAP;
        timer_d      = '0;
        state_d      = ST_IDLE;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      shreg_q          <= '0;
      bit_cnt_q        <= '0;
      oct_cnt_q        <= '0;
      timer_q          <= '0;
      octet_q          <= '0;
      octet_valid_q    <= 1'b0;
      octet_last_q     <= 1'b0;
      payload_length_q <= '0;
      plv_q            <= 1'b0;
      decode_end_q     <= 1'b0;
      crc_ok_q         <= 1'b0;
      abort_q          <= 1'b0;
      abort_code_q     <= ABORT_NONE;
    end else begin
      state_q          <= state_d;
      shreg_q          <= shreg_d;
      bit_cnt_q        <= bit_cnt_d;
      oct_cnt_q        <= oct_cnt_d;
      timer_q          <= timer_d;
      octet_q          <= octet_d;
      octet_valid_q    <= octet_valid_d;
      octet_last_q     <= octet_last_d;
      payload_length_q <= payload_length_d;
      plv_q            <= plv_d;
      decode_end_q     <= decode_end_d;
      crc_ok_q         <= crc_ok_d;
      abort_q          <= abort_d;
      abort_code_q     <= abort_code_d;
    end
  end

  // Qualifiers are single-cycle strobes with no back-pressure; a restart
  // abort is reported combinationally in the cycle start is seen.
  assign octet                = octet_q;
  assign octet_valid          = octet_valid_q;
  assign octet_last           = octet_last_q;
  assign payload_length       = payload_length_q;
  assign payload_length_valid = plv_q;
  assign decode_end           = decode_end_q;
  assign crc_ok               = crc_ok_q;
  assign abort                = ~rst & (abort_q | restart);
  assign abort_code           = rst ? ABORT_NONE : (restart ? ABORT_RESTART : abort_code_q);

endmodule

// File: tb/tb_btle_rx_deframer.sv
// Directed bench for btle_rx_deframer: default instance plus a MAX_PAYLOAD=31
// instance sharing the same stimulus.
module tb_btle_rx_deframer;

  logic        clk = 1'b0;
  logic        rst, start, legacy_mode, info_bit, bit_valid;
  logic [5:0]  channel_number;
  logic [23:0] crc_init;

  logic [7:0]  octet, payload_length;
  logic        octet_valid, octet_last, payload_length_valid, decode_end, crc_ok, abort, busy;
  logic [1:0]  abort_code;

  logic [7:0]  octet_m, payload_length_m;
  logic        octet_valid_m, octet_last_m, plv_m, decode_end_m, crc_ok_m, abort_m, busy_m;
  logic [1:0]  abort_code_m;

  btle_rx_deframer dut (
    .clk(clk), .rst(rst), .start(start), .legacy_mode(legacy_mode),
    .channel_number(channel_number), .crc_init(crc_init), .info_bit(info_bit),
    .bit_valid(bit_valid), .octet(octet), .octet_valid(octet_valid),
    .octet_last(octet_last), .payload_length(payload_length),
    .payload_length_valid(payload_length_valid), .decode_end(decode_end),
    .crc_ok(crc_ok), .abort(abort), .abort_code(abort_code), .busy(busy)
  );

  btle_rx_deframer #(.MAX_PAYLOAD(31)) dut_m (
    .clk(clk), .rst(rst), .start(start), .legacy_mode(legacy_mode),
    .channel_number(channel_number), .crc_init(crc_init), .info_bit(info_bit),
    .bit_valid(bit_valid), .octet(octet_m), .octet_valid(octet_valid_m),
    .octet_last(octet_last_m), .payload_length(payload_length_m),
    .payload_length_valid(plv_m), .decode_end(decode_end_m),
    .crc_ok(crc_ok_m), .abort(abort_m), .abort_code(abort_code_m), .busy(busy_m)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  int oct_seen, last_idx, plv_cnt, len_seen, de_cnt, de_neg, ab_cnt, ab_code, ab_neg;
  int plv1_cnt, de1_cnt, ab1_cnt, ab1_code, ab1_neg;
  int last_obs, obs16;
  logic start_ab;
  logic [1:0] start_code;

  logic [7:0] exp_q[$];
  logic [7:0] fb[$];
  logic       fbits[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [7:0] e;
    neg_cnt++;
    if (octet_valid) begin
      oct_seen++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("octet", octet, e);
      end
      if (octet_last) last_idx = oct_seen;
    end
    if (payload_length_valid) begin plv_cnt++; len_seen = payload_length; end
    if (decode_end) begin de_cnt++; de_neg = neg_cnt; end
    if (abort) begin ab_cnt++; ab_code = abort_code; ab_neg = neg_cnt; end
    if (plv_m) plv1_cnt++;
    if (decode_end_m) de1_cnt++;
    if (abort_m) begin ab1_cnt++; ab1_code = abort_code_m; ab1_neg = neg_cnt; end
  end

  function automatic logic [23:0] crc_step(input logic [23:0] r, input logic b);
    logic fbk;
    fbk = r[23] ^ b;
    return {r[22:0], 1'b0} ^ (fbk ? 24'h00065B : 24'h000000);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_stats();
    oct_seen = 0; last_idx = 0; plv_cnt = 0; len_seen = 0; de_cnt = 0; de_neg = -1;
    ab_cnt = 0; ab_code = 0; ab_neg = -1;
    plv1_cnt = 0; de1_cnt = 0; ab1_cnt = 0; ab1_code = 0; ab1_neg = -1;
    exp_q.delete();
  endtask

  // Builds header+payload bytes, appends the CRC that zeroes the register,
  // then optionally flips one payload bit (after the CRC was computed).
  task automatic make_frame(input logic [7:0] h0, input logic [7:0] h1,
                            input int npay, input int flip_bit);
    logic [23:0] r;
    logic [7:0]  t;
    fb.delete();
    fbits.delete();
    fb.push_back(h0);
    fb.push_back(h1);
    for (int i = 0; i < npay; i++) fb.push_back(8'(i * 37 + 5));
    r = crc_init;
    for (int i = 0; i < fb.size(); i++) begin
      t = fb[i];
      for (int j = 0; j < 8; j++) r = crc_step(r, t[j]);
    end
    if (flip_bit >= 0) begin
      t = fb[2 + flip_bit / 8];
      t[flip_bit % 8] = ~t[flip_bit % 8];
      fb[2 + flip_bit / 8] = t;
    end
    for (int i = 0; i < fb.size(); i++) begin
      t = fb[i];
      for (int j = 0; j < 8; j++) fbits.push_back(t[j]);
    end
    for (int j = 23; j >= 0; j--) fbits.push_back(r[j]);
  endtask

  task automatic push_exp(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back(fb[i]);
  endtask

  // The start cycle carries a junk bit that must be ignored.
  task automatic start_frame(input logic legacy, input logic [5:0] ch);
    legacy_mode    = legacy;
    channel_number = ch;
    start          = 1'b1;
    bit_valid      = 1'b1;
    info_bit       = 1'b1;
    #2;
    start_ab   = abort;
    start_code = abort_code;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input int from, input int to, input int stall_at, input int stall_len);
    for (int i = from; i < to; i++) begin
      if (i == stall_at) idle(stall_len);
      info_bit  = fbits[i];
      bit_valid = 1'b1;
      last_obs  = neg_cnt + 2;
      if (i == 15) obs16 = last_obs;
      tick();
      bit_valid = 1'b0;
    end
  endtask

  task automatic full_frame(input logic legacy, input logic [5:0] ch, input logic [7:0] h0,
                            input logic [7:0] h1, input int npay, input int flip_bit);
    clear_stats();
    make_frame(h0, h1, npay, flip_bit);
    push_exp(2 + npay);
    start_frame(legacy, ch);
    send_bits(0, fbits.size(), -1, 0);
    idle(3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; legacy_mode = 1'b0; info_bit = 1'b0; bit_valid = 1'b0;
    channel_number = 6'd0; crc_init = 24'h555555;
    clear_stats();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_octet_valid", octet_valid, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_abort", abort, 0);
    chk("rst_payload_length", payload_length, 0);
    rst = 1'b0;
    tick();

    // legacy advertising frame, 6 payload octets, 15-cycle stall mid-frame
    clear_stats();
    make_frame(8'h40, 8'h06, 6, -1);
    push_exp(8);
    start_frame(1'b1, 6'd37);
    send_bits(0, 88, 40, 15);
    idle(3);
    chk("adv_len", len_seen, 6);
    chk("adv_plv_cnt", plv_cnt, 1);
    chk("adv_octets", oct_seen, 8);
    chk("adv_last_idx", last_idx, 8);
    chk("adv_decode_end", de_cnt, 1);
    chk("adv_de_timing", de_neg, last_obs);
    chk("adv_crc_ok", crc_ok, 1);
    chk("adv_no_abort", ab_cnt, 0);
    chk("adv_exp_left", exp_q.size(), 0);
    idle(5);
    chk("adv_crc_ok_hold", crc_ok, 1);
    chk("adv_idle", busy, 0);

    // same frame with a flipped payload bit
    clear_stats();
    make_frame(8'h40, 8'h06, 6, 13);
    push_exp(8);
    start_frame(1'b1, 6'd37);
    chk("bad_crc_ok_cleared", crc_ok, 0);
    send_bits(0, 88, -1, 0);
    idle(3);
    chk("bad_decode_end", de_cnt, 1);
    chk("bad_crc_ok", crc_ok, 0);
    chk("bad_octets", oct_seen, 8);

    // legacy data channel: 5-bit length field
    full_frame(1'b1, 6'd5, 8'h02, 8'hE3, 3, -1);
    chk("data_len", len_seen, 3);
    chk("data_octets", oct_seen, 5);
    chk("data_last_idx", last_idx, 5);
    chk("data_crc_ok", crc_ok, 1);

    // legacy advertising channel 38: 6-bit length field
    full_frame(1'b1, 6'd38, 8'h00, 8'hE5, 37, -1);
    chk("adv38_len", len_seen, 37);
    chk("adv38_octets", oct_seen, 39);
    chk("adv38_crc_ok", crc_ok, 1);

    // zero-length payload goes straight to CRC
    full_frame(1'b0, 6'd10, 8'h01, 8'h00, 0, -1);
    chk("zero_len", len_seen, 0);
    chk("zero_octets", oct_seen, 2);
    chk("zero_last_idx", last_idx, 2);
    chk("zero_de_timing", de_neg, last_obs);
    chk("zero_crc_ok", crc_ok, 1);

    // maximum length frame; 31-octet instance rejects it
    full_frame(1'b0, 6'd20, 8'h02, 8'hFF, 255, -1);
    chk("max_len", len_seen, 255);
    chk("max_octets", oct_seen, 257);
    chk("max_last_idx", last_idx, 257);
    chk("max_de_timing", de_neg, last_obs);
    chk("max_crc_ok", crc_ok, 1);
    chk("max_exp_left", exp_q.size(), 0);
    chk("m_max_abort_code", ab1_code, 1);
    chk("m_max_no_de", de1_cnt, 0);

    // length 32 over the 31-octet limit
    full_frame(1'b0, 6'd20, 8'h02, 8'h20, 32, -1);
    chk("len32_octets", oct_seen, 34);
    chk("len32_crc_ok", crc_ok, 1);
    chk("m_len32_abort_cnt", ab1_cnt, 1);
    chk("m_len32_abort_code", ab1_code, 1);
    chk("m_len32_abort_timing", ab1_neg, obs16);
    chk("m_len32_no_plv", plv1_cnt, 0);
    chk("m_len32_no_de", de1_cnt, 0);

    // gap timeout after bit 20, later bits ignored
    clear_stats();
    make_frame(8'h40, 8'h06, 6, -1);
    push_exp(2);
    start_frame(1'b1, 6'd37);
    send_bits(0, 20, -1, 0);
    idle(16);
    idle(2);
    chk("gap_abort_cnt", ab_cnt, 1);
    chk("gap_abort_code", ab_code, 2);
    chk("gap_abort_timing", ab_neg, last_obs + 16);
    chk("gap_busy", busy, 0);
    send_bits(20, 40, -1, 0);
    idle(3);
    chk("gap_octets_after", oct_seen, 2);
    chk("gap_no_de", de_cnt, 0);
    chk("gap_busy_after", busy, 0);

    // restart after bit 30, then a complete frame
    clear_stats();
    make_frame(8'h40, 8'h06, 6, -1);
    push_exp(3);
    start_frame(1'b1, 6'd37);
    send_bits(0, 30, -1, 0);
    push_exp(8);
    start_frame(1'b1, 6'd37);
    chk("restart_same_cycle", start_ab, 1);
    chk("restart_code_same_cycle", start_code, 3);
    send_bits(0, 88, -1, 0);
    idle(3);
    chk("restart_abort_cnt", ab_cnt, 1);
    chk("restart_abort_code", ab_code, 3);
    chk("restart_octets", oct_seen, 11);
    chk("restart_de", de_cnt, 1);
    chk("restart_crc_ok", crc_ok, 1);

    // reset mid-frame, together with start
    clear_stats();
    make_frame(8'h40, 8'h06, 6, -1);
    push_exp(2);
    start_frame(1'b1, 6'd37);
    send_bits(0, 20, -1, 0);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    idle(3);
    chk("rst_mid_no_abort", ab_cnt, 0);
    chk("rst_mid_no_de", de_cnt, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_crc_ok", crc_ok, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btle_rx_deframer.md
BTLE_RX_DEFRAMER -- requirements
Module: btle_rx_deframer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  LEN_WIDTH, 8, payload length field width in bits.
  MAX_PAYLOAD, 255, largest accepted payload length in octets.
  CRC_STATE_BIT_WIDTH, 24, CRC register width.
  GAP_TIMEOUT, 16, maximum clk cycles allowed between bit_valid pulses while busy.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk, in, 1, sole clock.
  rst, in, 1, synchronous active-high reset.
  start, in, 1, access-address hit pulse that begins a frame.
  legacy_mode, in, 1, 1 = 6-bit advertising / 5-bit data length field; 0 = full 8-bit length field.
  channel_number, in, 6, channels 37, 38 and 39 are advertising; all others are data.
  crc_init, in, CRC_STATE_BIT_WIDTH, CRC seed, sampled on start.
  info_bit, in, 1, descrambled bit, transmitted LSB-first.
  bit_valid, in, 1, info_bit qualifier.
  octet, out, 8, assembled octet.
  octet_valid, out, 1, octet qualifier.
  octet_last, out, 1, marks the final header or payload octet.
  payload_length, out, LEN_WIDTH, decoded length.
  payload_length_valid, out, 1, one-cycle pulse.
  decode_end, out, 1, one-cycle pulse at frame completion.
  crc_ok, out, 1, CRC verdict, valid with decode_end.
  abort, out, 1, one-cycle pulse.
  abort_code, out, 2, 1 = length over MAX_PAYLOAD, 2 = gap timeout, 3 = restart.
  busy, out, 1, high in any state other than IDLE.

Function
REQ-003 The state machine SHALL have the states IDLE, HEADER, PAYLOAD and CRC; start moves it from any state to HEADER.
REQ-004 In every state, a bit_valid in the same cycle as start SHALL be ignored.
REQ-005 Bits SHALL be shifted into the octet LSB-first; octet_valid SHALL pulse one cycle after the bit_valid of bit 8 of every header and payload octet.
REQ-006 CRC octets SHALL NOT be output.
REQ-007 After header octet 1, payload_length SHALL be set as follows:
  legacy_mode=1 on an advertising channel: octet[5:0].
  legacy_mode=1 on a data channel: octet[4:0].
  legacy_mode=0: octet[7:0], zero-extended or truncated to LEN_WIDTH.
REQ-008 payload_length_valid SHALL pulse in the same cycle as the octet_valid of header octet 1.
REQ-009 A length of 0 SHALL go directly to CRC, with octet_last set on header octet 1; otherwise octet_last SHALL be set on payload octet payload_length-1.
REQ-010 If the length exceeds MAX_PAYLOAD, the block SHALL pulse abort with code 1, suppress payload_length_valid and return to IDLE.
REQ-011 The CRC register SHALL load crc_init on start and clock every accepted bit, including the 24 CRC bits.
REQ-012 The CRC register SHALL use polynomial 0x00065B (x^24+x^10+x^9+x^6+x^4+x^3+x+1).
REQ-013 One cycle after the bit_valid of the 24th CRC bit, decode_end SHALL pulse, crc_ok SHALL equal (register==0), and the state SHALL return to IDLE.
REQ-014 crc_ok SHALL hold its value until the next start or rst.
REQ-015 While busy, if GAP_TIMEOUT cycles elapse with no bit_valid, the block SHALL pulse abort with code 2 and return to IDLE; decode_end SHALL NOT pulse.
REQ-016 A start while busy SHALL pulse abort with code 3 in the same cycle and restart in HEADER with the bit and octet counters cleared.
REQ-017 The bit counter SHALL be wide enough for 8*(MAX_PAYLOAD+5) bits and SHALL NOT wrap within a frame.
REQ-018 bit_valid pulses in IDLE SHALL be ignored.

Reset
REQ-019 On rst, all outputs SHALL be 0, the state SHALL be IDLE, and the CRC register, counters and timer SHALL be 0.
REQ-020 rst SHALL take priority over start in the same cycle.
REQ-021 rst mid-frame SHALL produce no abort or decode_end pulse.

Structure
REQ-022 The state encoding, abort codes, the CRC polynomial constant and the advertising channel numbers SHALL live in the shared package btle_rx_pkg.
REQ-023 The CRC SHALL be the sub-module btle_crc24_lfsr, a serial LFSR with synchronous load and enable.

Verification
REQ-024 Legacy mode, channel 37, header 0x40 0x06, 6 payload octets, correct CRC -> payload_length=6; 8 octet_valid pulses, octet_last on the 8th; decode_end one cycle after bit 88; crc_ok=1.
REQ-025 Same frame with one payload bit flipped -> decode_end pulses with crc_ok=0.
REQ-026 legacy_mode=0, MAX_PAYLOAD=255, length 0xFF -> 257 octets output, decode_end after bit 2080. With MAX_PAYLOAD=31 and length 0x20 -> abort with code 1 after header octet 1, no decode_end.
REQ-027 Data channel 5, legacy_mode=1, header octet 1 = 0xE3 -> payload_length=3.
REQ-028 Stall for 16 cycles after bit 20 -> abort with code 2; bit_valid afterwards is ignored until start.
REQ-029 Second start at bit 30 -> abort with code 3, then a complete frame decodes with crc_ok=1.
